// File: rtl/interpolation_phase_timer_pkg.sv
// Phase codes shared by the decoder and the phase timer, plus the legal-successor table.
package interpolation_phase_timer_pkg;

    typedef enum logic [2:0] {
        PhIdle    = 3'd0,
        PhBegin   = 3'd1,
        PhPh      = 3'd2,
        PhPvpoSet = 3'd3,
        PhPvpo    = 3'd4,
        PhPvsoSet = 3'd5,
        PhPvso    = 3'd6,
        PhBegPvso = 3'd7
    } phase_e;

    // The one non-repeat, non-IDLE phase allowed to follow p.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PhIdle:    next_phase = PhBegin;
            PhBegin:   next_phase = PhPh;
            PhPh:      next_phase = PhPvpoSet;
            PhPvpoSet: next_phase = PhPvpo;
            PhPvpo:    next_phase = PhPvsoSet;
            PhPvsoSet: next_phase = PhPvso;
            PhPvso:    next_phase = PhBegPvso;
            PhBegPvso: next_phase = PhPh;
            default:   next_phase = PhIdle;
        endcase
    endfunction

endpackage

// File: rtl/interpolation_phase_decode.sv
// Combinational decode of the controller's enable/mux lines into a phase code.
// Earlier terms take priority; any non-zero pattern matching no term is illegal.
module interpolation_phase_decode
    import interpolation_phase_timer_pkg::*;
(
    input  logic   enable_reg_int,
    input  logic   enable_SR_integer,
    input  logic   enable_read_integer,
    input  logic   enable_read_horizontal,
    input  logic   mux_c0,
    input  logic   mux_c1,
    input  logic   clip_pvso,
    output logic   illegal,
    output phase_e code
);

    always_comb begin
        illegal = 1'b0;
        code    = PhIdle;
        if (mux_c0 && enable_reg_int) begin
            code = PhBegPvso;
        end else if (mux_c0 && clip_pvso) begin
            code = PhPvso;
        end else if (enable_read_integer && enable_read_horizontal) begin
            code = PhPvsoSet;
        end else if (enable_SR_integer && enable_read_integer) begin
            code = PhPvpoSet;
        end else if (enable_SR_integer) begin
            code = PhPh;
        end else if (enable_read_integer && mux_c1) begin
            code = PhPvpo;
        end else if (enable_reg_int) begin
            code = PhBegin;
        end else if ({enable_read_integer, enable_read_horizontal, mux_c0, mux_c1, clip_pvso}
                     != 5'b0) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/interpolation_phase_timer.sv
// Times the interpolation phases, raises *_finished pulses, counts blocks, checks sequencing.
// Optional watchdog enabled by defining INTERP_TIMER_WATCHDOG_EN.
module interpolation_phase_timer
    import interpolation_phase_timer_pkg::*;
#(
    parameter int unsigned PH_CYCLES   = 16,
    parameter int unsigned PVPO_CYCLES = 6,
    parameter int unsigned PVSO_CYCLES = 26,
    parameter int unsigned CNT_WIDTH   = 5,
    parameter int unsigned BLK_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable_reg_int,
    input  logic                 enable_SR_integer,
    input  logic                 enable_read_integer,
    input  logic                 enable_read_horizontal,
    input  logic                 mux_c0,
    input  logic                 mux_c1,
    input  logic                 clip_pvso,
    output logic                 PH_INTERPOLATION_finished,
    output logic                 PVPO_INTERPOLATION_finished,
    output logic                 PVSO_INTERPOLATION_finished,
    output logic [2:0]           phase,
    output logic                 block_done,
    output logic [BLK_WIDTH-1:0] block_count,
    output logic                 protocol_error,
    output logic                 timeout
);

    phase_e                 cur_code, phase_q;
    logic                   cur_ill, ill_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cur_len, prev_len;
    logic                   persist, blk_entry, err_q, err_d;
    logic                   ph_fin_q, pvpo_fin_q, pvso_fin_q, blk_done_q;
    logic [BLK_WIDTH-1:0]   blk_cnt_q;

    interpolation_phase_decode u_decode (
        .enable_reg_int         (enable_reg_int),
        .enable_SR_integer      (enable_SR_integer),
        .enable_read_integer    (enable_read_integer),
        .enable_read_horizontal (enable_read_horizontal),
        .mux_c0                 (mux_c0),
        .mux_c1                 (mux_c1),
        .clip_pvso              (clip_pvso),
        .illegal                (cur_ill),
        .code                   (cur_code)
    );

    // Zero marks an untimed phase.
    function automatic logic [CNT_WIDTH-1:0] len_of(input phase_e p);
        case (p)
            PhPh:    len_of = CNT_WIDTH'(PH_CYCLES);
            PhPvpo:  len_of = CNT_WIDTH'(PVPO_CYCLES);
            PhPvso:  len_of = CNT_WIDTH'(PVSO_CYCLES);
            default: len_of = '0;
        endcase
    endfunction

    always_comb begin
        persist   = !cur_ill && !ill_q && (cur_code == phase_q);
        cur_len   = len_of(cur_code);
        prev_len  = len_of(phase_q);
        blk_entry = !cur_ill && (cur_code == PhBegPvso) && (ill_q || phase_q != PhBegPvso);

        cnt_d = '0;
        if (!cur_ill && cur_len != '0) begin
            if (!persist) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != cur_len) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end

        err_d = err_q;
        if (cur_ill) begin
            err_d = 1'b1;
        end else if (!ill_q && !persist) begin
            if (cur_code != PhIdle && cur_code != next_phase(phase_q)) begin
                err_d = 1'b1;
            end
            if (prev_len != '0 && cnt_q < prev_len) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_q    <= PhIdle;
            ill_q      <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ph_fin_q   <= 1'b0;
            pvpo_fin_q <= 1'b0;
            pvso_fin_q <= 1'b0;
            blk_done_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            phase_q    <= cur_ill ? PhIdle : cur_code;
            ill_q      <= cur_ill;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            // Registered one cycle early so the pulse lines up with phase cycle LEN.
            ph_fin_q   <= persist && phase_q == PhPh   && cnt_q == CNT_WIDTH'(PH_CYCLES - 1);
            pvpo_fin_q <= persist && phase_q == PhPvpo && cnt_q == CNT_WIDTH'(PVPO_CYCLES - 1);
            pvso_fin_q <= persist && phase_q == PhPvso && cnt_q == CNT_WIDTH'(PVSO_CYCLES - 1);
            blk_done_q <= blk_entry;
            if (blk_entry) begin
                blk_cnt_q <= blk_cnt_q + BLK_WIDTH'(1);
            end
        end
    end

`ifdef INTERP_TIMER_WATCHDOG_EN
    logic [1:0] over_q;
    logic       timeout_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            over_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            // over_q counts saturated cycles; the third overrun edge means the pulse was ignored.
            if (persist && prev_len != '0 && cnt_q == prev_len) begin
                if (over_q == 2'd2) begin
                    timeout_q <= 1'b1;
                end else begin
                    over_q <= over_q + 2'd1;
                end
            end else begin
                over_q <= '0;
            end
            if (persist && (phase_q inside {PhBegin, PhPvpoSet, PhPvsoSet, PhBegPvso})) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign phase                       = phase_q;
    assign PH_INTERPOLATION_finished   = ph_fin_q;
    assign PVPO_INTERPOLATION_finished = pvpo_fin_q;
    assign PVSO_INTERPOLATION_finished = pvso_fin_q;
    assign block_done                  = blk_done_q;
    assign block_count                 = blk_cnt_q;
    assign protocol_error              = err_q;

endmodule

// File: tb/tb_interpolation_phase_timer.sv
// Directed bench for interpolation_phase_timer; a second instance with BLK_WIDTH=2 checks wrap.
module tb_interpolation_phase_timer;

    localparam int PH_LEN   = 16;
    localparam int PVPO_LEN = 6;
    localparam int PVSO_LEN = 26;
    // Phase codes as driven by the bench; 8 means an illegal pattern.
    localparam int C_IDLE = 0, C_BEGIN = 1, C_PH = 2, C_PVPO_SET = 3, C_PVPO = 4;
    localparam int C_PVSO_SET = 5, C_PVSO = 6, C_BEG_PVSO = 7, C_ILL = 8;
`ifdef INTERP_TIMER_WATCHDOG_EN
    localparam int WD_EXP = 1;
`else
    localparam int WD_EXP = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable_reg_int, enable_SR_integer, enable_read_integer, enable_read_horizontal;
    logic mux_c0, mux_c1, clip_pvso;

    logic       ph_fin, pvpo_fin, pvso_fin, block_done, protocol_error, timeout;
    logic [2:0] phase;
    logic [7:0] block_count;

    logic       w_ph_fin, w_pvpo_fin, w_pvso_fin, w_block_done, w_protocol_error, w_timeout;
    logic [2:0] w_phase;
    logic [1:0] w_block_count;

    int n_checks = 0;
    int n_fail   = 0;

    interpolation_phase_timer dut (
        .clock                       (clock),
        .reset                       (reset),
        .enable_reg_int              (enable_reg_int),
        .enable_SR_integer           (enable_SR_integer),
        .enable_read_integer         (enable_read_integer),
        .enable_read_horizontal      (enable_read_horizontal),
        .mux_c0                      (mux_c0),
        .mux_c1                      (mux_c1),
        .clip_pvso                   (clip_pvso),
        .PH_INTERPOLATION_finished   (ph_fin),
        .PVPO_INTERPOLATION_finished (pvpo_fin),
        .PVSO_INTERPOLATION_finished (pvso_fin),
        .phase                       (phase),
        .block_done                  (block_done),
        .block_count                 (block_count),
        .protocol_error              (protocol_error),
        .timeout                     (timeout)
    );

    interpolation_phase_timer #(.BLK_WIDTH(2)) dut_w (
        .clock                       (clock),
        .reset                       (reset),
        .enable_reg_int              (enable_reg_int),
        .enable_SR_integer           (enable_SR_integer),
        .enable_read_integer         (enable_read_integer),
        .enable_read_horizontal      (enable_read_horizontal),
        .mux_c0                      (mux_c0),
        .mux_c1                      (mux_c1),
        .clip_pvso                   (clip_pvso),
        .PH_INTERPOLATION_finished   (w_ph_fin),
        .PVPO_INTERPOLATION_finished (w_pvpo_fin),
        .PVSO_INTERPOLATION_finished (w_pvso_fin),
        .phase                       (w_phase),
        .block_done                  (w_block_done),
        .block_count                 (w_block_count),
        .protocol_error              (w_protocol_error),
        .timeout                     (w_timeout)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int code);
        {enable_reg_int, enable_SR_integer, enable_read_integer, enable_read_horizontal,
         mux_c0, mux_c1, clip_pvso} = 7'b0;
        case (code)
            C_BEGIN:    enable_reg_int = 1'b1;
            C_PH:       enable_SR_integer = 1'b1;
            C_PVPO_SET: begin enable_SR_integer = 1'b1; enable_read_integer = 1'b1; end
            C_PVPO:     begin enable_read_integer = 1'b1; mux_c1 = 1'b1; end
            C_PVSO_SET: begin enable_read_integer = 1'b1; enable_read_horizontal = 1'b1; end
            C_PVSO:     begin mux_c0 = 1'b1; clip_pvso = 1'b1; end
            C_BEG_PVSO: begin mux_c0 = 1'b1; enable_reg_int = 1'b1; end
            C_ILL:      mux_c0 = 1'b1;
            default:    ;
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold a phase for cycles first..last of its instance, checking pulses every cycle.
    task automatic hold(input int code, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(code);
            tick();
            check_eq($sformatf("phase c%0d i%0d", code, i), phase, (code == C_ILL) ? 0 : code);
            check_eq($sformatf("ph_fin c%0d i%0d", code, i), ph_fin,
                     (code == C_PH && i == PH_LEN));
            check_eq($sformatf("pvpo_fin c%0d i%0d", code, i), pvpo_fin,
                     (code == C_PVPO && i == PVPO_LEN));
            check_eq($sformatf("pvso_fin c%0d i%0d", code, i), pvso_fin,
                     (code == C_PVSO && i == PVSO_LEN));
            check_eq($sformatf("block_done c%0d i%0d", code, i), block_done,
                     (code == C_BEG_PVSO && i == 1));
        end
    endtask

    task automatic block();
        hold(C_PH, 1, PH_LEN);
        hold(C_PVPO_SET, 1, 1);
        hold(C_PVPO, 1, PVPO_LEN);
        hold(C_PVSO_SET, 1, 1);
        hold(C_PVSO, 1, PVSO_LEN);
        hold(C_BEG_PVSO, 1, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(C_IDLE);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " phase"}, phase, 0);
        check_eq({tag, " fins"}, {ph_fin, pvpo_fin, pvso_fin}, 0);
        check_eq({tag, " block_done"}, block_done, 0);
        check_eq({tag, " block_count"}, block_count, 0);
        check_eq({tag, " protocol_error"}, protocol_error, 0);
        check_eq({tag, " timeout"}, timeout, 0);
    endtask

    initial begin
        drive(C_IDLE);
        do_reset();
        check_all_zero("reset");

        // Full nominal sequence, first block.
        hold(C_IDLE, 1, 1);
        hold(C_BEGIN, 1, 1);
        block();
        check_eq("t1 block_count", block_count, 1);
        check_eq("t1 protocol_error", protocol_error, 0);
        check_eq("t1 timeout", timeout, 0);

        // Two more blocks make three, then two more for the wrap check.
        block();
        block();
        check_eq("t2 block_count3", block_count, 3);
        block();
        block();
        check_eq("t2 block_count5", block_count, 5);
        check_eq("t2 wrap block_count", w_block_count, 1);
        check_eq("t2 protocol_error", protocol_error, 0);

        // Early exit from PH.
        do_reset();
        hold(C_IDLE, 1, 1);
        hold(C_BEGIN, 1, 1);
        hold(C_PH, 1, 10);
        check_eq("t3 err before exit", protocol_error, 0);
        hold(C_PVPO_SET, 1, 1);
        check_eq("t3 err after exit", protocol_error, 1);
        hold(C_IDLE, 1, 3);
        check_eq("t3 err sticky", protocol_error, 1);
        do_reset();
        check_eq("t3 err cleared", protocol_error, 0);

        // Illegal decode.
        hold(C_ILL, 1, 1);
        check_eq("t4 err illegal", protocol_error, 1);

        // Reset in the middle of PVSO, then a fresh PVSO instance.
        do_reset();
        hold(C_IDLE, 1, 1);
        hold(C_BEGIN, 1, 1);
        hold(C_PH, 1, PH_LEN);
        hold(C_PVPO_SET, 1, 1);
        hold(C_PVPO, 1, PVPO_LEN);
        hold(C_PVSO_SET, 1, 1);
        hold(C_PVSO, 1, 20);
        check_eq("t5 count pre", block_count, 0);
        reset = 1'b0;
        tick();
        check_all_zero("t5 midreset");
        reset = 1'b1;
        hold(C_PVSO, 1, PVSO_LEN);
        check_eq("t5 err idle->pvso", protocol_error, 1);

        // Watchdog: PVPO held past its length.
        do_reset();
        hold(C_IDLE, 1, 1);
        hold(C_BEGIN, 1, 1);
        hold(C_PH, 1, PH_LEN);
        hold(C_PVPO_SET, 1, 1);
        hold(C_PVPO, 1, 8);
        check_eq("t6 timeout c8", timeout, 0);
        hold(C_PVPO, 9, 9);
        check_eq("t6 timeout c9", timeout, WD_EXP);
        check_eq("t6 err", protocol_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
